// File: rtl/barrier_damage_arbiter_pkg.sv
// Shared game constants for barrier damage handling: coordinate width,
// requester indices and the encoding of the damage issue FSM.
package barrier_damage_arbiter_pkg;

   localparam int GAME_COORD_W = 11;
   localparam int GAME_NUM_REQ = 4;

   // Requester slots: the player shot owns slot 0, alien shots follow.
   localparam int REQ_PLAYER = 0;
   localparam int REQ_ALIEN0 = 1;
   localparam int REQ_ALIEN1 = 2;
   localparam int REQ_ALIEN2 = 3;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_GAP   = 2'd2
   } issue_state_e;

endpackage

// File: rtl/barrier_damage_arbiter_damage_fifo.sv
// Small synchronous FIFO holding queued damage events. Read data is the
// current head (show-ahead); flush clears pointers and occupancy.
module damage_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 22
) (
   input  logic                     clk,
   input  logic                     flush,
   input  logic                     push,
   input  logic                     pop,
   input  logic [W-1:0]             wdata,
   output logic [W-1:0]             rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW    = $clog2(DEPTH);
   localparam int CNT_W = AW + 1;

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign rdata   = mem[rd_ptr];

   // Storage write; contents need no reset since count gates every read.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

   // Pointer and occupancy bookkeeping; pointers wrap naturally (power-of-two depth).
   always_ff @(posedge clk) begin
      if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/barrier_damage_arbiter.sv
// Serialises barrier-hit requests from the projectile engines onto the
// barrier store's single damage port: round-robin accept into a FIFO, then
// one new_damage pulse per entry followed by a forced idle gap so each
// read-modify-write of barrier health finishes before the next.
//
// Handshake: req[i] is a level held with stable req_x/req_y until ack[i]
// pulses for one cycle; ack is registered, so it appears the cycle after
// the request was sampled and the entry was written into the FIFO. A
// requester whose ack is high is ignored that cycle so a held request is
// never taken twice. new_damage is a one-cycle pulse with damage_x/y valid
// alongside it; there is no back-pressure from the barrier store.
module barrier_damage_arbiter
   import barrier_damage_arbiter_pkg::*;
#(
   parameter int NUM_REQ    = GAME_NUM_REQ,
   parameter int FIFO_DEPTH = 4,
   parameter int DMG_GAP    = 2,
   parameter int COORD_W    = GAME_COORD_W
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          restart,
   input  logic [NUM_REQ-1:0]            req,
   input  logic [NUM_REQ*COORD_W-1:0]    req_x,
   input  logic [NUM_REQ*COORD_W-1:0]    req_y,
   output logic [NUM_REQ-1:0]            ack,
   output logic [COORD_W-1:0]            damage_x,
   output logic [COORD_W-1:0]            damage_y,
   output logic                          new_damage,
   output logic [$clog2(FIFO_DEPTH):0]   queue_count,
   output logic                          busy,
   output issue_state_e                  state_dbg
);

   localparam int RW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic                   flush;
   logic [NUM_REQ-1:0]     eligible;
   logic [RW-1:0]          rr_ptr;
   logic [RW-1:0]          winner;
   logic                   found;
   logic                   accept;
   logic [COORD_W-1:0]     push_x;
   logic [COORD_W-1:0]     push_y;
   logic [2*COORD_W-1:0]   head;
   logic                   fifo_full;
   logic                   fifo_empty;
   logic                   pop;
   logic [3:0]             gap_cnt;
   issue_state_e           state;

   // Game restart behaves exactly like reset on every piece of state.
   assign flush = rst | restart;

   // Round-robin search: first eligible requester at or above rr_ptr, wrapping.
   always_comb begin
      eligible = req & ~ack;
      found    = 1'b0;
      winner   = '0;
      push_x   = '0;
      push_y   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && eligible[i] && (((int'(rr_ptr) + k) % NUM_REQ) == i)) begin
               found  = 1'b1;
               winner = RW'(i);
               push_x = req_x[i*COORD_W +: COORD_W];
               push_y = req_y[i*COORD_W +: COORD_W];
            end
         end
      end
   end

   // Full is judged on registered occupancy, so a same-cycle pop never frees a slot.
   assign accept = found & ~fifo_full;
   assign pop    = (state == ST_IDLE) & ~fifo_empty;

   damage_fifo #(
      .DEPTH (FIFO_DEPTH),
      .W     (2*COORD_W)
   ) u_fifo (
      .clk   (clk),
      .flush (flush),
      .push  (accept),
      .pop   (pop),
      .wdata ({push_x, push_y}),
      .rdata (head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (queue_count)
   );

   // Registered ack pulse and round-robin pointer advance past the winner.
   always_ff @(posedge clk) begin
      if (flush) begin
         ack    <= '0;
         rr_ptr <= '0;
      end else begin
         ack <= accept ? (NUM_REQ'(1) << winner) : '0;
         if (accept) rr_ptr <= (winner == RW'(NUM_REQ-1)) ? '0 : winner + 1'b1;
      end
   end

   // Issue FSM: pop head in IDLE, pulse new_damage in ISSUE, hold off in GAP.
   always_ff @(posedge clk) begin
      if (flush) begin
         state      <= ST_IDLE;
         gap_cnt    <= '0;
         new_damage <= 1'b0;
         damage_x   <= '0;
         damage_y   <= '0;
      end else begin
         new_damage <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (!fifo_empty) begin
                  {damage_x, damage_y} <= head;
                  new_damage           <= 1'b1;
                  state                <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               if (DMG_GAP == 0) begin
                  state <= ST_IDLE;
               end else begin
                  gap_cnt <= 4'(DMG_GAP);
                  state   <= ST_GAP;
               end
            end
            ST_GAP: begin
               if (gap_cnt <= 4'd1) begin
                  gap_cnt <= '0;
                  state   <= ST_IDLE;
               end else begin
                  gap_cnt <= gap_cnt - 4'd1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign busy      = ~fifo_empty | (state != ST_IDLE);
   assign state_dbg = state;

endmodule
